// File: rtl/rx_4phase_pkg.sv
// Shared definitions for the four-phase receive endpoint: data-width default
// and FSM state encoding (also used by the matching transmitter).
package rx_4phase_pkg;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;
endpackage

// File: rtl/rx_4phase_sync_2ff.sv
// Parameterized-depth flop-chain synchronizer with async active-high reset.
// Legal depths are 2 and 3.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];
endmodule

// File: rtl/rx_4phase.sv
// Four-phase bundled-data receiver: synchronizes req, captures input_rx into a
// 2-entry FIFO and completes the handshake on ack; consumer pops via rd.
module rx_4phase
    import rx_4phase_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] input_rx,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] output_rx,
    output logic                  d,
    output logic                  f,
    input  logic                  rd
);
    logic req_s;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk  (clk),
        .reset(reset),
        .din  (req),
        .dout (req_s)
    );

    state_t                state, state_nxt;
    logic                  wr_en, pop, has_room;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    // Room is judged from the registered count only; a same-cycle pop does not
    // make space for a same-cycle write.
    assign has_room = (count < 2'd2);
    assign pop      = rd && d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_s && has_room) state_nxt = ACKED;
            ACKED:   if (!req_s)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack is the state flop itself, so it stays glitch-free.
    always_comb begin
        ack   = (state == ACKED);
        wr_en = (state == IDLE) && req_s && has_room;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            case ({wr_en, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= input_rx;
        end
    end

    assign output_rx = mem[rd_ptr];
    assign d         = (count != 2'd0);
    assign f         = (count == 2'd2);
endmodule

// File: tb/tb_rx_4phase.sv
// Directed and randomized bench for rx_4phase with a queue scoreboard.
module tb_rx_4phase;
    logic       clk = 1'b0;
    logic       reset, req, rd;
    logic [7:0] input_rx, output_rx;
    logic       ack, d, f;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    bit         mon_en = 1'b0;

    rx_4phase #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .input_rx (input_rx),
        .ack      (ack),
        .output_rx(output_rx),
        .d        (d),
        .f        (f),
        .rd       (rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int k;
        k = 0;
        while (ack !== lvl && k < 100) begin
            tick();
            k++;
        end
        check(tag, ack, lvl);
    endtask

    task automatic send_full(input logic [7:0] data);
        input_rx = data;
        req      = 1'b1;
        sb.push_back(data);
        wait_ack(1'b1, "send_ack_hi");
        req = 1'b0;
        wait_ack(1'b0, "send_ack_lo");
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_sb"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, {d, output_rx}, {1'b1, e});
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    // The transmitter only drops req after seeing ack, so any ack rise must find req high.
    always @(posedge ack) if (mon_en) check("ack_rise_req", req, 1'b1);

    initial begin
        int tmo, got, cyc;
        logic rnext;
        reset = 1'b1; req = 1'b0; rd = 1'b0; input_rx = 8'h00;
        tick(); tick();
        check("rst_ack", ack, 1'b0);
        check("rst_dfo", {d, f, output_rx}, 10'h000);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single word: latency of ack/d and of ack release
        input_rx = 8'hA5; req = 1'b1; sb.push_back(8'hA5);
        tick(); tick();
        check("single_ack_e2", ack, 1'b0);
        tick();
        check("single_e3", {ack, d, f, output_rx}, {1'b1, 1'b1, 1'b0, 8'hA5});
        req = 1'b0;
        tick(); tick();
        check("single_ack_hold", ack, 1'b1);
        tick();
        check("single_ack_lo", ack, 1'b0);
        pop_check("single_data");
        check("single_empty", d, 1'b0);

        // Backpressure: third word must wait for a slot
        send_full(8'h11);
        send_full(8'h22);
        check("bp_full", {d, f}, 2'b11);
        input_rx = 8'h33; req = 1'b1; sb.push_back(8'h33);
        repeat (6) tick();
        check("bp_no_ack", ack, 1'b0);
        pop_check("bp_pop11");
        tick();
        check("bp_ack33", ack, 1'b1);
        req = 1'b0;
        wait_ack(1'b0, "bp_ack_lo");
        pop_check("bp_pop22");
        pop_check("bp_pop33");
        check("bp_empty", d, 1'b0);

        // Simultaneous write and pop at count=1
        send_full(8'h44);
        input_rx = 8'h55; req = 1'b1; sb.push_back(8'h55);
        tick(); tick();
        pop_check("sim_pop44");
        check("sim_after", {ack, d, f, output_rx}, {1'b1, 1'b1, 1'b0, 8'h55});
        req = 1'b0;
        wait_ack(1'b0, "sim_ack_lo");
        pop_check("sim_pop55");

        // Full buffer: pop in the same cycle as req_s blocks the write for one cycle
        send_full(8'h66);
        send_full(8'h77);
        input_rx = 8'h88; req = 1'b1; sb.push_back(8'h88);
        tick(); tick();
        pop_check("blk_pop66");
        check("blk_no_wr", {ack, f}, 2'b00);
        tick();
        check("blk_wr", {ack, f}, 2'b11);
        req = 1'b0;
        wait_ack(1'b0, "blk_ack_lo");
        pop_check("blk_pop77");
        pop_check("blk_pop88");

        // Async reset while ACKED with two words held
        send_full(8'h99);
        input_rx = 8'hAA; req = 1'b1;
        wait_ack(1'b1, "rst_mid_ack");
        check("rst_mid_full", f, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_async", {ack, d, f, output_rx}, 11'h000);
        sb.delete();
        tick(); tick();
        reset = 1'b0;
        sb.push_back(8'hAA);
        tick(); tick();
        check("rst_re_e2", ack, 1'b0);
        tick();
        check("rst_re_e3", {ack, d, output_rx}, {1'b1, 1'b1, 8'hAA});
        req = 1'b0;
        wait_ack(1'b0, "rst_re_lo");
        pop_check("rst_re_data");

        // Randomized phase and consumer stalls
        tmo = 0; got = 0; cyc = 0;
        fork
            begin
                int k;
                for (int i = 0; i < 1000; i++) begin
                    @(posedge clk);
                    #($urandom_range(1, 9));
                    input_rx = 8'($urandom);
                    sb.push_back(input_rx);
                    req = 1'b1;
                    k = 0;
                    while (!ack && k < 200) begin @(posedge clk); #1; k++; end
                    if (!ack) tmo++;
                    #($urandom_range(0, 8));
                    req = 1'b0;
                    k = 0;
                    while (ack && k < 200) begin @(posedge clk); #1; k++; end
                    if (ack) tmo++;
                end
            end
            begin
                while (got < 1000 && cyc < 60000) begin
                    @(posedge clk);
                    #2;
                    cyc++;
                    rnext = ($urandom_range(0, 3) != 0);
                    if (rnext && d) begin
                        check("rand_sb", sb.size() > 0, 1);
                        if (sb.size() > 0) check("rand_data", output_rx, sb.pop_front());
                        got++;
                    end
                    rd = rnext;
                end
                @(posedge clk);
                #2;
                rd = 1'b0;
            end
        join
        tick(); tick();
        check("rand_count", got, 1000);
        check("rand_tmo", tmo, 0);
        check("rand_sb_left", sb.size(), 0);
        check("rand_empty", d, 1'b0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
